// File: rtl/i2c_target_pkg.sv
// Shared definitions for the I2C target endpoint: state encoding, frame
// layout constants and the read-byte selection helper.
package i2c_target_pkg;

    typedef enum logic [3:0] {
        k_t_idle     = 4'd0,
        k_t_addr     = 4'd1,
        k_t_addr_ack = 4'd2,
        k_t_wr_data  = 4'd3,
        k_t_wr_ack   = 4'd4,
        k_t_rd_data  = 4'd5,
        k_t_rd_ack   = 4'd6,
        k_t_ignore   = 4'd7
    } t_state_e;

    localparam int   RW_BIT    = 0;
    localparam logic ACK_LVL   = 1'b0;
    localparam logic NACK_LVL  = 1'b1;
    localparam logic [7:0] IDLE_BYTE = 8'hFF;

    // An empty source reads back as an all-ones byte, as a released bus would.
    function automatic logic [7:0] pick_tx_byte(input logic valid, input logic [7:0] data);
        return valid ? data : IDLE_BYTE;
    endfunction

endpackage

// File: rtl/i2c_target_line_filter.sv
// Two-flop synchronizer plus debounce for one I2C line; emits one-cycle
// rise/fall pulses aligned with the cycle the filtered value changes.
module i2c_line_filter #(
    parameter int FILTER_LEN = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic line_in,
    output logic line_filt,
    output logic rise,
    output logic fall
);

    logic       sync_p0;
    logic       sync_p1;
    logic [3:0] cnt;
    logic       settled;

    assign settled = (cnt == 4'(FILTER_LEN - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_p0   <= 1'b1;
            sync_p1   <= 1'b1;
            line_filt <= 1'b1;
            cnt       <= '0;
            rise      <= 1'b0;
            fall      <= 1'b0;
        end else begin
            sync_p0 <= line_in;
            sync_p1 <= sync_p0;
            rise    <= 1'b0;
            fall    <= 1'b0;
            // Any sample agreeing with the current value restarts the run.
            if (sync_p1 == line_filt) begin
                cnt <= '0;
            end else if (settled) begin
                cnt       <= '0;
                line_filt <= sync_p1;
                rise      <= sync_p1;
                fall      <= ~sync_p1;
            end else begin
                cnt <= cnt + 4'd1;
            end
        end
    end

endmodule

// File: rtl/i2c_target.sv
// I2C target endpoint with 7-bit addressing: write bytes are strobed out on
// rx_valid, read bytes are pulled from a valid/ready source.
module i2c_target
    import i2c_target_pkg::*;
#(
    parameter logic [6:0] ADDR       = 7'h42,
    parameter int         FILTER_LEN = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_out,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_underrun,
    output logic       busy
);

    logic scl_f, scl_rise, scl_fall;
    logic sda_f, sda_rise, sda_fall;

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
        .clk       (clk),
        .reset     (reset),
        .line_in   (scl_in),
        .line_filt (scl_f),
        .rise      (scl_rise),
        .fall      (scl_fall)
    );

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
        .clk       (clk),
        .reset     (reset),
        .line_in   (sda_in),
        .line_filt (sda_f),
        .rise      (sda_rise),
        .fall      (sda_fall)
    );

    logic start_det, stop_det, bit_rise, bit_fall;

    assign start_det = sda_fall & scl_f;
    assign stop_det  = sda_rise & scl_f;
    // A bus condition swallows any SCL edge landing in the same cycle.
    assign bit_rise  = scl_rise & ~start_det & ~stop_det;
    assign bit_fall  = scl_fall & ~start_det & ~stop_det;

    t_state_e   state;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic       is_read;
    logic       byte_full;
    logic       ack_in;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= k_t_idle;
            bit_cnt     <= '0;
            is_read     <= 1'b0;
            byte_full   <= 1'b0;
            ack_in      <= NACK_LVL;
            sda_out     <= 1'b1;
            rx_data     <= 8'h00;
            rx_valid    <= 1'b0;
            tx_ready    <= 1'b0;
            tx_underrun <= 1'b0;
            busy        <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            tx_ready    <= 1'b0;
            tx_underrun <= 1'b0;
            if (start_det) begin
                state     <= k_t_addr;
                bit_cnt   <= '0;
                byte_full <= 1'b0;
                busy      <= 1'b1;
                sda_out   <= 1'b1;
            end else if (stop_det) begin
                state     <= k_t_idle;
                byte_full <= 1'b0;
                busy      <= 1'b0;
                sda_out   <= 1'b1;
            end else begin
                case (state)
                    k_t_addr: begin
                        if (bit_rise) begin
                            shreg   <= {shreg[6:0], sda_f};
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) byte_full <= 1'b1;
                        end else if (bit_fall && byte_full) begin
                            byte_full <= 1'b0;
                            is_read   <= shreg[RW_BIT];
                            if (shreg[7:1] == ADDR) begin
                                sda_out <= ACK_LVL;
                                state   <= k_t_addr_ack;
                                // Read data is fetched while the address ACK is on the bus.
                                if (shreg[RW_BIT]) begin
                                    shreg       <= pick_tx_byte(tx_valid, tx_data);
                                    tx_ready    <= tx_valid;
                                    tx_underrun <= ~tx_valid;
                                end
                            end else begin
                                state <= k_t_ignore;
                            end
                        end
                    end
                    k_t_addr_ack: begin
                        if (bit_fall) begin
                            bit_cnt <= '0;
                            if (is_read) begin
                                sda_out <= shreg[7];
                                state   <= k_t_rd_data;
                            end else begin
                                sda_out <= 1'b1;
                                state   <= k_t_wr_data;
                            end
                        end
                    end
                    k_t_wr_data: begin
                        if (bit_rise) begin
                            shreg   <= {shreg[6:0], sda_f};
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                rx_data   <= {shreg[6:0], sda_f};
                                rx_valid  <= 1'b1;
                                byte_full <= 1'b1;
                            end
                        end else if (bit_fall && byte_full) begin
                            byte_full <= 1'b0;
                            sda_out   <= ACK_LVL;
                            state     <= k_t_wr_ack;
                        end
                    end
                    k_t_wr_ack: begin
                        if (bit_fall) begin
                            sda_out <= 1'b1;
                            bit_cnt <= '0;
                            state   <= k_t_wr_data;
                        end
                    end
                    k_t_rd_data: begin
                        if (bit_fall) begin
                            if (bit_cnt == 3'd7) begin
                                sda_out <= 1'b1;
                                bit_cnt <= '0;
                                state   <= k_t_rd_ack;
                            end else begin
                                sda_out <= shreg[6];
                                shreg   <= {shreg[6:0], 1'b0};
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end
                    end
                    k_t_rd_ack: begin
                        if (bit_rise) begin
                            ack_in <= sda_f;
                        end else if (bit_fall) begin
                            if (ack_in == ACK_LVL) begin
                                shreg       <= pick_tx_byte(tx_valid, tx_data);
                                tx_ready    <= tx_valid;
                                tx_underrun <= ~tx_valid;
                                sda_out     <= tx_valid ? tx_data[7] : 1'b1;
                                bit_cnt     <= '0;
                                state       <= k_t_rd_data;
                            end else begin
                                sda_out <= 1'b1;
                                state   <= k_t_ignore;
                            end
                        end
                    end
                    default: begin
                        sda_out <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// Bench acting as I2C controller and tx byte source; expected bus levels and
// strobes come from a transaction-level model of the target.
module tb_i2c_target;

    localparam logic [6:0] ADDR       = 7'h42;
    localparam int         FILTER_LEN = 3;
    localparam int         Q          = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       scl_drv = 1'b1;
    logic       sda_drv = 1'b1;
    logic       sda_wire;
    logic       sda_out, rx_valid, tx_ready, tx_underrun, busy;
    logic [7:0] rx_data;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;

    assign sda_wire = sda_drv & sda_out;

    i2c_target #(.ADDR(ADDR), .FILTER_LEN(FILTER_LEN)) dut (
        .clk         (clk),
        .reset       (reset),
        .scl_in      (scl_drv),
        .sda_in      (sda_wire),
        .sda_out     (sda_out),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_underrun (tx_underrun),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic       chk_sda  = 1'b0;
    logic       exp_sda  = 1'b1;
    logic       exp_busy = 1'b0;
    logic [7:0] rx_exp[$];
    logic [7:0] tx_q[$];
    logic [7:0] rd_log[$];
    logic       tx_en = 1'b0;
    int n_ready = 0, n_under = 0, exp_ready = 0, exp_under = 0;

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_byte(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Byte source with valid/ready handshake.
    always @(negedge clk) begin
        if (tx_ready && tx_q.size() != 0) void'(tx_q.pop_front());
        tx_valid = tx_en && (tx_q.size() != 0);
        tx_data  = (tx_q.size() != 0) ? tx_q[0] : 8'h00;
    end

    // Per-cycle comparison of outputs against the model.
    always @(negedge clk) begin
        logic [7:0] want;
        if (chk_sda) begin
            check_bit("sda_out", sda_out, exp_sda);
            check_bit("busy", busy, exp_busy);
        end
        if (rx_valid) begin
            if (rx_exp.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rx_unexpected: got strobe with %02h, none expected", rx_data);
            end else begin
                want = rx_exp.pop_front();
                check_byte("rx_data", rx_data, want);
            end
        end
        if (rx_valid || tx_ready) check_bit("rx_tx_overlap", rx_valid & tx_ready, 1'b0);
        if (tx_ready) n_ready++;
        if (tx_underrun) n_under++;
    end

    task automatic xfer_bit(input logic drv, input logic exp_dut, input logic glitch, output logic seen);
        sda_drv = drv;
        wait_clks(Q);
        scl_drv = 1'b1;
        exp_sda = exp_dut;
        chk_sda = 1'b1;
        if (glitch) begin
            wait_clks(Q / 2);
            sda_drv = ~drv;
            wait_clks(1);
            sda_drv = drv;
            wait_clks(Q - Q / 2 - 1);
        end else begin
            wait_clks(Q);
        end
        seen = sda_wire;
        wait_clks(Q);
        chk_sda = 1'b0;
        scl_drv = 1'b0;
        wait_clks(Q);
    endtask

    task automatic start_cond();
        sda_drv = 1'b1;
        wait_clks(Q);
        scl_drv = 1'b1;
        wait_clks(2 * Q);
        sda_drv = 1'b0;
        wait_clks(2 * Q);
        scl_drv = 1'b0;
        exp_busy = 1'b1;
        wait_clks(Q);
    endtask

    task automatic stop_cond();
        sda_drv = 1'b0;
        wait_clks(Q);
        scl_drv = 1'b1;
        wait_clks(2 * Q);
        sda_drv = 1'b1;
        exp_busy = 1'b0;
        wait_clks(2 * Q);
        check_bit("busy_after_stop", busy, 1'b0);
        check_bit("sda_after_stop", sda_out, 1'b1);
    endtask

    task automatic write_byte(input logic [7:0] b, input logic acked, input logic [7:0] gmask);
        logic seen;
        for (int i = 7; i >= 0; i--) xfer_bit(b[i], 1'b1, gmask[i], seen);
        xfer_bit(1'b1, acked ? 1'b0 : 1'b1, 1'b0, seen);
        check_bit("ack_slot_line", seen, acked ? 1'b0 : 1'b1);
    endtask

    task automatic read_byte(input logic [7:0] exp, input logic ctrl_ack, output logic [7:0] got);
        logic seen;
        for (int i = 7; i >= 0; i--) begin
            xfer_bit(1'b1, exp[i], 1'b0, seen);
            got[i] = seen;
        end
        xfer_bit(ctrl_ack ? 1'b0 : 1'b1, 1'b1, 1'b0, seen);
    endtask

    // One addressed transfer; the model decides ACKs, rx bytes and tx bytes.
    task automatic txn(input logic [6:0] a, input logic rw, input int n, input logic [7:0] wdat[4],
                       input logic en, input logic [7:0] gmask, input logic stop_after);
        logic       match;
        logic [7:0] snap[$];
        logic [7:0] want, got;
        int         avail;
        match = (a == ADDR);
        tx_en = en;
        snap  = tx_q;
        avail = en ? snap.size() : 0;
        start_cond();
        write_byte({a, rw}, match, 8'h00);
        if (!rw) begin
            for (int k = 0; k < n; k++) begin
                if (match) rx_exp.push_back(wdat[k]);
                write_byte(wdat[k], match, gmask);
            end
        end else if (match) begin
            for (int k = 0; k < n; k++) begin
                if (k < avail) begin
                    want = snap[k];
                    exp_ready++;
                end else begin
                    want = 8'hFF;
                    exp_under++;
                end
                read_byte(want, k < n - 1, got);
                check_byte("rd_byte", got, want);
                rd_log.push_back(got);
            end
        end
        if (stop_after) stop_cond();
        check_int("tx_ready_count", n_ready, exp_ready);
        check_int("tx_underrun_count", n_under, exp_under);
        check_int("rx_pending", rx_exp.size(), 0);
    endtask

    initial begin
        logic [7:0] wd[4];
        logic [7:0] pre_rdy;
        logic       seen;
        logic [6:0] a;
        logic       rw;
        int         n;

        // Reset values
        wait_clks(4);
        check_bit("rst_sda_out", sda_out, 1'b1);
        check_byte("rst_rx_data", rx_data, 8'h00);
        check_bit("rst_rx_valid", rx_valid, 1'b0);
        check_bit("rst_tx_ready", tx_ready, 1'b0);
        check_bit("rst_tx_underrun", tx_underrun, 1'b0);
        check_bit("rst_busy", busy, 1'b0);
        reset = 1'b0;
        wait_clks(10);

        // 1-clk SDA glitch while idle must not start a transfer
        sda_drv = 1'b0;
        wait_clks(1);
        sda_drv = 1'b1;
        wait_clks(20);
        check_bit("glitch_idle_busy", busy, 1'b0);

        // Write 0xA5 with a 1-clk glitch in every data bit's high phase
        wd = '{8'hA5, 8'h00, 8'h00, 8'h00};
        txn(ADDR, 1'b0, 1, wd, 1'b0, 8'hFF, 1'b1);
        check_byte("write_a5_literal", rx_data, 8'hA5);

        // Read 0x3C (ACKed) then 0xC3 (NACKed)
        rd_log.delete();
        tx_q.push_back(8'h3C);
        tx_q.push_back(8'hC3);
        pre_rdy = 8'(n_ready);
        txn(ADDR, 1'b1, 2, wd, 1'b1, 8'h00, 1'b1);
        check_byte("read_byte0_literal", rd_log[0], 8'h3C);
        check_byte("read_byte1_literal", rd_log[1], 8'hC3);
        check_int("read_two_ready", n_ready - int'(pre_rdy), 2);

        // Foreign address 0x48: no ACK, no rx strobe
        wd = '{8'h5A, 8'h00, 8'h00, 8'h00};
        txn(7'h48, 1'b0, 1, wd, 1'b0, 8'h00, 1'b1);

        // Read with an empty source: one underrun, bus carries 0xFF
        rd_log.delete();
        tx_en = 1'b0;
        txn(ADDR, 1'b1, 1, wd, 1'b0, 8'h00, 1'b1);
        check_byte("underrun_literal", rd_log[0], 8'hFF);
        check_int("underrun_once", n_under, 1);

        // Write 0x11, repeated START, read without an intervening STOP
        wd = '{8'h11, 8'h00, 8'h00, 8'h00};
        txn(ADDR, 1'b0, 1, wd, 1'b0, 8'h00, 1'b0);
        check_byte("rep_start_rx_literal", rx_data, 8'h11);
        tx_q.push_back(8'h96);
        rd_log.delete();
        txn(ADDR, 1'b1, 1, wd, 1'b1, 8'h00, 1'b1);
        check_byte("rep_start_rd_literal", rd_log[0], 8'h96);

        // Reset while the target drives the address ACK
        start_cond();
        for (int i = 7; i >= 0; i--) xfer_bit(((8'h84 >> i) & 8'h01) != 0, 1'b1, 1'b0, seen);
        sda_drv = 1'b1;
        wait_clks(Q);
        scl_drv = 1'b1;
        exp_sda = 1'b0;
        chk_sda = 1'b1;
        wait_clks(Q / 2);
        chk_sda = 1'b0;
        reset = 1'b1;
        wait_clks(1);
        reset = 1'b0;
        check_bit("midrst_sda_out", sda_out, 1'b1);
        check_bit("midrst_busy", busy, 1'b0);
        exp_busy = 1'b0;
        wait_clks(2 * Q - Q / 2 - 1);
        scl_drv = 1'b0;
        wait_clks(Q);
        write_byte(8'h84, 1'b0, 8'h00);
        write_byte(8'h33, 1'b0, 8'h00);
        stop_cond();
        check_int("midrst_rx_pending", rx_exp.size(), 0);
        wd = '{8'h5A, 8'h00, 8'h00, 8'h00};
        txn(ADDR, 1'b0, 1, wd, 1'b0, 8'h00, 1'b1);
        check_byte("after_rst_literal", rx_data, 8'h5A);

        // Randomized transfers, mixed with repeated STARTs
        for (int t = 0; t < 14; t++) begin
            a  = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : ADDR;
            rw = 1'($urandom_range(0, 1));
            n  = $urandom_range(1, 3);
            for (int k = 0; k < 4; k++) wd[k] = 8'($urandom_range(0, 255));
            for (int k = $urandom_range(0, 2); k > 0; k--) tx_q.push_back(8'($urandom_range(0, 255)));
            txn(a, rw, n, wd, $urandom_range(0, 3) != 0, 8'($urandom_range(0, 255)),
                (t == 13) || ($urandom_range(0, 1) == 1));
        end

        wait_clks(20);
        check_bit("final_busy", busy, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_target.md
Name: i2c_target

Overview:
- I2C target (slave) endpoint, 7-bit addressing. Counterpart to the team's I2C controller transmit path.
- Filters the raw SCL/SDA lines and detects START, repeated START and STOP.
- Write transfers: matches the address, ACKs, and delivers each received byte on a one-cycle strobe.
- Read transfers: takes bytes from a valid/ready source and shifts them onto SDA, MSB first.

Parameters:
- ADDR, 7'h42, own 7-bit target address.
- FILTER_LEN, 3, consecutive equal synchronized samples needed before a filtered line changes (range 1..15).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- scl_in  in  1  raw SCL pad input.
- sda_in  in  1  raw SDA pad input.
- sda_out  out  1  open-drain SDA control: 0 = drive low, 1 = release.
- rx_data  out  8  last byte written by the controller.
- rx_valid  out  1  one-cycle strobe; rx_data is valid in that cycle.
- tx_data  in  8  next byte to return on a read.
- tx_valid  in  1  tx_data is available.
- tx_ready  out  1  one-cycle strobe; tx_data is consumed in that cycle.
- tx_underrun  out  1  one-cycle strobe; a read byte was needed while tx_valid was 0.
- busy  out  1  high from START until STOP.

Behaviour:
- Reset values: sda_out=1, rx_data=8'h00, rx_valid=0, tx_ready=0, tx_underrun=0, busy=0, state=k_t_idle, filtered lines=1.
- Line filter:
  - Each line passes through a 2-flop synchronizer, then the filter.
  - The filtered value changes only after FILTER_LEN identical samples.
  - Latency from pad to filtered value is 2+FILTER_LEN clks.
  - Edges are one-cycle pulses derived from the filtered values.
- Bus conditions (from filtered lines):
  - START: SDA falls while SCL=1.
  - STOP: SDA rises while SCL=1.
  - Both are recognised in every state and take priority over bit activity.
  - START (including repeated START) → k_t_addr, bit counter=0, busy=1, sda_out=1.
  - STOP → k_t_idle, busy=0, sda_out=1.
- Bit timing:
  - Received bits are sampled on the filtered SCL rising edge.
  - sda_out changes only on the filtered SCL falling edge, never while SCL=1.
- States (4-bit encoding):
  - k_t_idle: waits for START.
  - k_t_addr: shifts 8 bits in (7 address bits + R/W).
    - On the 8th falling edge with address==ADDR: sda_out=0 and go to k_t_addr_ack.
    - If the address does not match: go to k_t_ignore.
    - If R/W=1 (read): the tx byte is loaded in the same falling-edge cycle.
      - tx_valid=1: shift register=tx_data and pulse tx_ready.
      - tx_valid=0: load 8'hFF and pulse tx_underrun.
  - k_t_addr_ack: on the next falling edge, release SDA.
    - Write: go to k_t_wr_data.
    - Read: drive the MSB of the shift register and go to k_t_rd_data.
  - k_t_wr_data: shifts 8 bits in.
    - On the 8th rising edge: rx_data=shifted byte and rx_valid pulses in that same cycle.
    - On the following falling edge: sda_out=0 and go to k_t_wr_ack. Write data is always ACKed.
  - k_t_wr_ack: on a falling edge, release SDA and go to k_t_wr_data with the counter cleared.
  - k_t_rd_data:
    - Shifts out bit 6..0 on successive falling edges.
    - On the 8th falling edge: release SDA and go to k_t_rd_ack.
  - k_t_rd_ack: samples the controller's ACK on the rising edge.
    - ACK (0): on the next falling edge, load the next byte (same tx_ready/tx_underrun rule), drive its MSB and go to k_t_rd_data.
    - NACK (1): go to k_t_ignore.
  - k_t_ignore: SDA released; waits for START or STOP.
- Bit counter: 3-bit, wraps 7→0. An ACK slot is marked by the ack state, not by the counter.
- Simultaneous events:
  - START/STOP in the same cycle as an SCL edge: the bus condition wins and the edge is discarded.
  - rx_valid and tx_ready never occur in the same cycle.
- Reset mid-transfer: returns to the reset values on the next clk and releases SDA immediately. The bus is then ignored until a fresh START.
- sda_out is registered. It is never driven 0 in k_t_idle or k_t_ignore.

Decomposition:
- include/i2c.vh gains:
  - the target state constants k_t_idle, k_t_addr, k_t_addr_ack, k_t_wr_data, k_t_wr_ack, k_t_rd_data, k_t_rd_ack, k_t_ignore;
  - the R/W bit position;
  - the ACK/NACK level constants.
- One sub-module, i2c_line_filter (parameter FILTER_LEN). It contains the synchronizer, the debounce and the rise/fall pulse outputs, and is instantiated once per line.

Test Plan:
- START, 0x84 (addr 0x42, W), byte 0xA5, STOP → sda_out=0 in both ACK slots; one rx_valid with rx_data=8'hA5; busy falls after STOP.
- START, 0x85 (R) with tx_valid=1 and tx_data=8'h3C; controller ACKs, then byte 2 (tx_data=8'hC3) is NACKed; STOP → SDA carries 00111100 then 11000011; exactly two tx_ready pulses; SDA released after the NACK.
- START, 0x90 (addr 0x48) → no ACK (sda_out stays 1 throughout); no rx_valid; state k_t_ignore until STOP.
- Read with tx_valid=0 → tx_underrun pulses once; SDA carries 8'hFF.
- Write 0x84, 0x11, repeated START, 0x85 read → rx_data=8'h11 delivered; the new address is ACKed; the read byte is loaded with no intervening STOP.
- A 1-clk SDA glitch while SCL=1 (FILTER_LEN=3) → no START/STOP detected. reset asserted mid-byte → sda_out=1 on the next clk; the following bits are ignored until START.
